// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 11 has no legal encoding, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge (little-endian).
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  lane_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign lane_shift = {addr_lo, 3'b000};

  always_comb begin
    byte_sel = 8'(mem_word >> lane_shift);
    half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: load_data = mem_word;
    endcase
  end

  always_comb begin
    store_word = mem_word;
    case (size)
      SZ_BYTE: store_word[lane_shift +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-organised data memory; one access in flight at a time.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned WORD_ADDR_W = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LSU_req,
  input  logic        LSU_we,
  input  logic [1:0]  LSU_size,
  input  logic        LSU_unsigned,
  input  logic [31:0] LSU_addr,
  input  logic [31:0] LSU_wdata,
  output logic        LSU_busy,
  output logic        LSU_done,
  output logic        LSU_misaligned,
  output logic [31:0] LSU_rdata,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic [31:0] word_index;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        unused_addr_bits;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign word_index       = 32'(LSU_addr[WORD_ADDR_W+1:2]);
  assign unused_addr_bits = ^LSU_addr[31:WORD_ADDR_W+2];

  dmem_lsu_align u_align (
    .size        (size_q),
    .addr_lo     (addr_lo_q),
    .is_unsigned (unsigned_q),
    .mem_word    (DMEM_data_out),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      size_q         <= SZ_BYTE;
      unsigned_q     <= 1'b0;
      addr_lo_q      <= 2'b00;
      wdata_q        <= '0;
      LSU_busy       <= 1'b0;
      LSU_done       <= 1'b0;
      LSU_misaligned <= 1'b0;
      LSU_rdata      <= '0;
      DMEM_address   <= '0;
      DMEM_data_in   <= '0;
      DMEM_mem_write <= 1'b0;
      DMEM_mem_read  <= 1'b0;
    end else begin
      LSU_done       <= 1'b0;
      LSU_misaligned <= 1'b0;
      DMEM_mem_write <= 1'b0;
      DMEM_mem_read  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (LSU_req) begin
            we_q         <= LSU_we;
            size_q       <= LSU_size;
            unsigned_q   <= LSU_unsigned;
            addr_lo_q    <= LSU_addr[1:0];
            wdata_q      <= LSU_wdata;
            DMEM_address <= word_index;
            LSU_busy     <= 1'b1;
            if (is_misaligned(LSU_size, LSU_addr[1:0])) begin
              state_q        <= DONE;
              LSU_done       <= 1'b1;
              LSU_misaligned <= 1'b1;
            end else if (!LSU_we || LSU_size != SZ_WORD) begin
              state_q       <= READ;
              DMEM_mem_read <= 1'b1;
            end else begin
              state_q        <= WRITE;
              DMEM_mem_write <= 1'b1;
              DMEM_data_in   <= LSU_wdata;
            end
          end
        end
        READ: begin
          // Read data is combinational, so the merge/extract uses it directly this cycle.
          if (we_q) begin
            state_q        <= WRITE;
            DMEM_mem_write <= 1'b1;
            DMEM_data_in   <= store_word;
          end else begin
            state_q   <= DONE;
            LSU_done  <= 1'b1;
            LSU_rdata <= load_data;
          end
        end
        WRITE: begin
          state_q  <= DONE;
          LSU_done <= 1'b1;
        end
        DONE: begin
          state_q  <= IDLE;
          LSU_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: table-driven vectors scored through a queue.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mis;
    logic [31:0] exp_data;  // load result, or merged word written for stores
  } vec_t;

  typedef struct {
    int          issue_cyc;
    int          lat;
    int          rd;
    int          wr;
    int          base_rd;
    int          base_wr;
    logic        mis;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] waddr;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        LSU_req, LSU_we, LSU_unsigned;
  logic [1:0]  LSU_size;
  logic [31:0] LSU_addr, LSU_wdata;
  logic        LSU_busy, LSU_done, LSU_misaligned;
  logic [31:0] LSU_rdata, DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  logic [31:0] mem [256];
  exp_t        sb [$];
  exp_t        me;
  vec_t        vecs [18];
  int          nvec = 0;
  int          nmis = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        mon_off = 1'b0;
  logic [31:0] last_rdata = '0;

  dmem_lsu #(.WORD_ADDR_W(8)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .LSU_req        (LSU_req),
    .LSU_we         (LSU_we),
    .LSU_size       (LSU_size),
    .LSU_unsigned   (LSU_unsigned),
    .LSU_addr       (LSU_addr),
    .LSU_wdata      (LSU_wdata),
    .LSU_busy       (LSU_busy),
    .LSU_done       (LSU_done),
    .LSU_misaligned (LSU_misaligned),
    .LSU_rdata      (LSU_rdata),
    .DMEM_address   (DMEM_address),
    .DMEM_data_in   (DMEM_data_in),
    .DMEM_mem_write (DMEM_mem_write),
    .DMEM_mem_read  (DMEM_mem_read),
    .DMEM_data_out  (DMEM_data_out)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign DMEM_data_out = mem[DMEM_address[7:0]];
  always @(posedge CLK) if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard side: count memory strobes and retire expectations on LSU_done.
  always @(negedge CLK) begin
    if (!mon_off) begin
      if (sb.size() == 0) begin
        if (LSU_done || DMEM_mem_read || DMEM_mem_write) begin
          nvec++;
          nmis++;
          $display("FAIL idle_activity: done=%b rd=%b wr=%b with nothing outstanding",
                   LSU_done, DMEM_mem_read, DMEM_mem_write);
        end
      end else begin
        if (DMEM_mem_read) begin
          rd_cnt++;
          chk("rd_addr", DMEM_address, sb[0].waddr);
        end
        if (DMEM_mem_write) begin
          wr_cnt++;
          chk("wr_addr", DMEM_address, sb[0].waddr);
          chk("wr_data", DMEM_data_in, sb[0].wdata);
        end
        if (LSU_done) begin
          me = sb.pop_front();
          chk("latency", 32'(cyc - me.issue_cyc), 32'(me.lat));
          chk("misaligned", {31'b0, LSU_misaligned}, {31'b0, me.mis});
          chk("rdata", LSU_rdata, me.rdata);
          chk("busy_in_done", {31'b0, LSU_busy}, 32'd1);
          chk("read_count", 32'(rd_cnt - me.base_rd), 32'(me.rd));
          chk("write_count", 32'(wr_cnt - me.base_wr), 32'(me.wr));
        end
      end
    end
  end

  // Drives a request (call at negedge+1) and pushes the expected outcome.
  task automatic issue(input vec_t v, input logic hold);
    exp_t e;
    LSU_req      = 1'b1;
    LSU_we       = v.we;
    LSU_size     = v.size;
    LSU_unsigned = v.uns;
    LSU_addr     = v.addr;
    LSU_wdata    = v.wdata;
    e.issue_cyc  = cyc;
    e.base_rd    = rd_cnt;
    e.base_wr    = wr_cnt;
    e.mis        = v.mis;
    if (v.mis) begin
      e.lat = 1; e.rd = 0; e.wr = 0;
    end else if (!v.we) begin
      e.lat = 2; e.rd = 1; e.wr = 0;
    end else if (v.size == SZ_WORD) begin
      e.lat = 2; e.rd = 0; e.wr = 1;
    end else begin
      e.lat = 3; e.rd = 1; e.wr = 1;
    end
    e.rdata    = (!v.we && !v.mis) ? v.exp_data : last_rdata;
    last_rdata = e.rdata;
    e.wdata    = v.exp_data;
    e.waddr    = {24'b0, v.addr[9:2]};
    sb.push_back(e);
    if (!hold) begin
      @(posedge CLK);
      #1 LSU_req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 12) begin
      @(negedge CLK);
      #1 n++;
    end
    if (sb.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL timeout: %0d accesses still outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, LSU_busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, LSU_done}, 32'd0);
    chk({tag, "_mis"}, {31'b0, LSU_misaligned}, 32'd0);
    chk({tag, "_mem_read"}, {31'b0, DMEM_mem_read}, 32'd0);
    chk({tag, "_mem_write"}, {31'b0, DMEM_mem_write}, 32'd0);
    chk({tag, "_rdata"}, LSU_rdata, 32'd0);
    chk({tag, "_address"}, DMEM_address, 32'd0);
    chk({tag, "_data_in"}, DMEM_data_in, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vh;
    logic seen_done, seen_wr;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[3] = 32'h8899AABB;
    mem[5] = 32'h12345678;
    mem[7] = 32'h55667788;

    //           we    size     uns   addr        wdata          mis   expected
    vecs[0]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000000E, 32'h0,        1'b0, 32'hFFFFFF99};
    vecs[1]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000000E, 32'h0,        1'b0, 32'h00000099};
    vecs[2]  = '{1'b0, SZ_HALF, 1'b0, 32'h0000000C, 32'h0,        1'b0, 32'hFFFFAABB};
    vecs[3]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000000E, 32'h0,        1'b0, 32'h00008899};
    vecs[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h00000014, 32'h0,        1'b0, 32'h12345678};
    vecs[5]  = '{1'b0, SZ_BYTE, 1'b0, 32'h00000017, 32'h0,        1'b0, 32'h00000012};
    vecs[6]  = '{1'b1, SZ_HALF, 1'b0, 32'h0000000E, 32'h00001234, 1'b0, 32'h1234AABB};
    vecs[7]  = '{1'b0, SZ_WORD, 1'b0, 32'h0000000C, 32'h0,        1'b0, 32'h1234AABB};
    vecs[8]  = '{1'b1, SZ_BYTE, 1'b0, 32'h00000015, 32'hFFFFFFC3, 1'b0, 32'h1234C378};
    vecs[9]  = '{1'b0, SZ_WORD, 1'b0, 32'h00000014, 32'h0,        1'b0, 32'h1234C378};
    vecs[10] = '{1'b1, SZ_WORD, 1'b0, 32'h00000018, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h00000418, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[12] = '{1'b1, SZ_WORD, 1'b0, 32'h00000002, 32'h11111111, 1'b1, 32'h0};
    vecs[13] = '{1'b0, SZ_HALF, 1'b0, 32'h0000000D, 32'h0,        1'b1, 32'h0};
    vecs[14] = '{1'b0, 2'b11,   1'b0, 32'h0000000C, 32'h0,        1'b1, 32'h0};
    vecs[15] = '{1'b0, SZ_HALF, 1'b0, 32'h00000016, 32'h0,        1'b0, 32'h00001234};
    vecs[16] = '{1'b0, SZ_WORD, 1'b0, 32'h00000400, 32'h0,        1'b0, 32'h00000000};
    vecs[17] = '{1'b0, SZ_BYTE, 1'b0, 32'h0000000C, 32'h0,        1'b0, 32'hFFFFFFBB};

    RST_N = 1'b0;
    LSU_req = 1'b0; LSU_we = 1'b0; LSU_size = 2'b00; LSU_unsigned = 1'b0;
    LSU_addr = '0; LSU_wdata = '0;
    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    #1 RST_N = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      #1 issue(vecs[i], 1'b0);
      wait_idle();
    end

    // Request held through a sub-word store: one access only, next one after DONE.
    vh = '{1'b1, SZ_HALF, 1'b0, 32'h0000001A, 32'hFFFFBEEF, 1'b0, 32'hBEEFBEEF};
    @(negedge CLK);
    #1 issue(vh, 1'b1);
    wait_idle();
    @(negedge CLK);
    #1 chk("busy_after_done", {31'b0, LSU_busy}, 32'd0);
    vh = '{1'b0, SZ_WORD, 1'b0, 32'h00000018, 32'h0, 1'b0, 32'hBEEFBEEF};
    issue(vh, 1'b0);
    wait_idle();

    // Reset pulsed during the READ cycle of a byte store.
    mon_off = 1'b1;
    @(negedge CLK);
    #1;
    LSU_req = 1'b1; LSU_we = 1'b1; LSU_size = SZ_BYTE; LSU_unsigned = 1'b0;
    LSU_addr = 32'h0000001C; LSU_wdata = 32'h000000AA;
    @(posedge CLK);
    #1 LSU_req = 1'b0;
    chk("abort_in_read", {31'b0, DMEM_mem_read}, 32'd1);
    RST_N = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge CLK);
    #1 RST_N = 1'b1;
    seen_done = 1'b0;
    seen_wr = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      seen_done |= LSU_done;
      seen_wr   |= DMEM_mem_write;
    end
    chk("abort_no_done", {31'b0, seen_done}, 32'd0);
    chk("abort_no_write", {31'b0, seen_wr}, 32'd0);
    chk("abort_mem_unchanged", mem[7], 32'h55667788);
    last_rdata = '0;
    mon_off = 1'b0;

    // Unit is usable again after the abort.
    vh = '{1'b0, SZ_BYTE, 1'b1, 32'h0000001F, 32'h0, 1'b0, 32'h00000055};
    @(negedge CLK);
    #1 issue(vh, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
